// File: rtl/mem_port_arbiter.sv
// Shared main-memory port arbiter for I-cache refill and D-cache refill/writeback.
// One fixed-length burst per grant; round-robin on ties; stalls the pipeline on D traffic.
module mem_port_arbiter #(
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [31:0]                   i_addr,
    output logic                          i_rvalid,
    output logic [31:0]                   i_rdata,
    output logic [$clog2(LINE_WORDS)-1:0] i_widx,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [31:0]                   d_addr,
    input  logic [31:0]                   d_wdata,
    output logic                          d_wready,
    output logic                          d_rvalid,
    output logic [31:0]                   d_rdata,
    output logic [$clog2(LINE_WORDS)-1:0] d_widx,
    output logic                          d_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic                          mem_stall
);

    localparam int WI = $clog2(LINE_WORDS);
    localparam int OFF = WI + 2;
    localparam logic [31:0] LMASK = ~((32'd1 << OFF) - 32'd1);
    localparam logic [WI-1:0] LAST = WI'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [WI-1:0] cnt, cnt_nxt;
    logic          last_d, last_d_nxt;
    logic [31:0]   base, base_nxt;
    logic          burst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last_d <= 1'b0;
            base   <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last_d <= last_d_nxt;
            base   <= base_nxt;
        end
    end

    // last_d doubles as the "granted side" marker while the burst and DONE run
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        last_d_nxt = last_d;
        base_nxt   = base;
        unique case (state)
            IDLE: begin
                if (d_req && (!i_req || !last_d)) begin
                    state_nxt  = d_we ? D_WR : D_RD;
                    base_nxt   = d_addr & LMASK;
                    cnt_nxt    = '0;
                    last_d_nxt = 1'b1;
                end else if (i_req) begin
                    state_nxt  = I_RD;
                    base_nxt   = i_addr & LMASK;
                    cnt_nxt    = '0;
                    last_d_nxt = 1'b0;
                end
            end
            I_RD, D_RD, D_WR: begin
                if (mem_ack) begin
                    cnt_nxt = cnt + WI'(1);
                    if (cnt == LAST) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        burst     = (state == I_RD) || (state == D_RD) || (state == D_WR);
        mem_req   = burst;
        mem_we    = (state == D_WR);
        mem_addr  = burst ? base + {{(30 - WI){1'b0}}, cnt, 2'b00} : 32'd0;
        mem_wdata = (state == D_WR) ? d_wdata : 32'd0;
        i_rvalid  = (state == I_RD) && mem_ack;
        d_rvalid  = (state == D_RD) && mem_ack;
        d_wready  = (state == D_WR) && mem_ack;
        i_done    = (state == DONE) && !last_d;
        d_done    = (state == DONE) && last_d;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
        i_widx    = cnt;
        d_widx    = cnt;
        mem_stall = d_req & ~d_done;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic [1:0]  i_widx;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [1:0]  d_widx;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic [7:0]  hs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_widx(i_widx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wready(d_wready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_widx(d_widx), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall)
    );

    // {mem_req, mem_we, i_rvalid, d_rvalid, d_wready, i_done, d_done, mem_stall}
    assign hs = {mem_req, mem_we, i_rvalid, d_rvalid,
                 d_wready, i_done, d_done, mem_stall};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; mem_ack = 0; mem_rdata = 0;
        #2;
        checks++;
        if (hs !== 8'h00) begin
            errors++;
            $display("FAIL reset_hs: got %b expected %b", hs, 8'h00);
        end
        checks++;
        if ({mem_addr, mem_wdata, i_widx, d_widx} !== 68'd0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h widx %0d/%0d expected 0",
                     mem_addr, mem_wdata, i_widx, d_widx);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_i_refill();
        i_req = 1; i_addr = 32'h1004; mem_ack = 1;
        #1;
        checks++;
        if (hs !== 8'h00) begin
            errors++;
            $display("FAIL i_idle: got %b expected %b", hs, 8'h00);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            mem_rdata = 32'hC0DE_0000 + k;
            #1;
            checks++;
            if (hs !== 8'hA0) begin
                errors++;
                $display("FAIL i_beat%0d_hs: got %b expected %b", k, hs, 8'hA0);
            end
            checks++;
            if (mem_addr !== 32'h1000 + 4 * k || i_widx !== 2'(k)) begin
                errors++;
                $display("FAIL i_beat%0d_addr: got %h/%0d expected %h/%0d",
                         k, mem_addr, i_widx, 32'h1000 + 4 * k, k);
            end
            checks++;
            if (i_rdata !== 32'hC0DE_0000 + k) begin
                errors++;
                $display("FAIL i_beat%0d_rdata: got %h expected %h",
                         k, i_rdata, 32'hC0DE_0000 + k);
            end
        end
        tick();
        mem_ack = 0;
        #1;
        checks++;
        if (hs !== 8'h04) begin
            errors++;
            $display("FAIL i_done: got %b expected %b", hs, 8'h04);
        end
        tick();
        i_req = 0;
        #1;
        checks++;
        if (hs !== 8'h00) begin
            errors++;
            $display("FAIL i_done_single: got %b expected %b", hs, 8'h00);
        end
        tick();
    endtask

    task automatic test_d_writeback();
        int wr = 0;
        logic [7:0] exp;
        d_req = 1; d_we = 1; d_addr = 32'h2000; mem_ack = 0;
        #1;
        checks++;
        if (hs !== 8'h01) begin
            errors++;
            $display("FAIL d_stall_rise: got %b expected %b", hs, 8'h01);
        end
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                tick();
                mem_ack = (w == 2);
                d_wdata = 32'hA500_0000 + k;
                #1;
                exp = (w == 2) ? 8'hC9 : 8'hC1;
                if (d_wready) wr++;
                checks++;
                if (hs !== exp) begin
                    errors++;
                    $display("FAIL d_wr%0d_%0d_hs: got %b expected %b", k, w, hs, exp);
                end
                checks++;
                if (mem_wdata !== 32'hA500_0000 + k || mem_addr !== 32'h2000 + 4 * k ||
                    d_widx !== 2'(k)) begin
                    errors++;
                    $display("FAIL d_wr%0d_%0d_bus: wdata %h addr %h idx %0d expected %h %h %0d",
                             k, w, mem_wdata, mem_addr, d_widx,
                             32'hA500_0000 + k, 32'h2000 + 4 * k, k);
                end
            end
        end
        tick();
        mem_ack = 0;
        #1;
        checks++;
        if (hs !== 8'h02) begin
            errors++;
            $display("FAIL d_done_nostall: got %b expected %b", hs, 8'h02);
        end
        checks++;
        if (wr !== 4) begin
            errors++;
            $display("FAIL d_wready_count: got %0d expected 4", wr);
        end
        tick();
        d_req = 0; d_we = 0;
        #1;
        checks++;
        if (hs !== 8'h00) begin
            errors++;
            $display("FAIL d_after_done: got %b expected %b", hs, 8'h00);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        rst = 1;
        tick();
        rst = 0;
        i_req = 1; i_addr = 32'h3000;
        d_req = 1; d_we = 0; d_addr = 32'h4000; mem_ack = 1;
        #1;
        checks++;
        if (hs !== 8'h01) begin
            errors++;
            $display("FAIL sim_idle0: got %b expected %b", hs, 8'h01);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (hs !== 8'h91 || mem_addr !== 32'h4000 + 4 * k) begin
                errors++;
                $display("FAIL sim_d%0d: got %b/%h expected %b/%h",
                         k, hs, mem_addr, 8'h91, 32'h4000 + 4 * k);
            end
        end
        tick();
        checks++;
        if (hs !== 8'h02) begin
            errors++;
            $display("FAIL sim_d_done: got %b expected %b", hs, 8'h02);
        end
        tick();
        d_req = 0;
        #1;
        checks++;
        if (hs !== 8'h00) begin
            errors++;
            $display("FAIL sim_gap: got %b expected %b", hs, 8'h00);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (hs !== 8'hA0 || mem_addr !== 32'h3000 + 4 * k) begin
                errors++;
                $display("FAIL sim_i%0d: got %b/%h expected %b/%h",
                         k, hs, mem_addr, 8'hA0, 32'h3000 + 4 * k);
            end
        end
        tick();
        checks++;
        if (hs !== 8'h04) begin
            errors++;
            $display("FAIL sim_i_done: got %b expected %b", hs, 8'h04);
        end
        tick();
        i_req = 0;
        tick();
    endtask

    task automatic test_fairness();
        logic       exp_d;
        logic [7:0] exp;
        logic [31:0] b_addr;
        i_req = 1; i_addr = 32'h7000;
        d_req = 1; d_we = 0; d_addr = 32'h8000; mem_ack = 1;
        for (int b = 0; b < 4; b++) begin
            exp_d = (b % 2 == 0);
            exp = exp_d ? 8'h91 : 8'hA1;
            b_addr = exp_d ? 32'h8000 : 32'h7000;
            #1;
            checks++;
            if (hs !== 8'h01) begin
                errors++;
                $display("FAIL fair%0d_idle: got %b expected %b", b, hs, 8'h01);
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (hs !== exp || mem_addr !== b_addr + 4 * k) begin
                    errors++;
                    $display("FAIL fair%0d_beat%0d: got %b/%h expected %b/%h",
                             b, k, hs, mem_addr, exp, b_addr + 4 * k);
                end
            end
            tick();
            exp = exp_d ? 8'h02 : 8'h05;
            checks++;
            if (hs !== exp) begin
                errors++;
                $display("FAIL fair%0d_done: got %b expected %b", b, hs, exp);
            end
            tick();
        end
        i_req = 0; d_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        i_req = 1; i_addr = 32'h5000; mem_ack = 1;
        tick();
        tick();
        tick();
        mem_ack = 0;
        #1;
        checks++;
        if (i_widx !== 2'd2 || mem_addr !== 32'h5008) begin
            errors++;
            $display("FAIL rm_pre: got %0d/%h expected 2/%h", i_widx, mem_addr, 32'h5008);
        end
        rst = 1;
        #1;
        checks++;
        if (hs !== 8'h00 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || i_widx !== 2'd0) begin
            errors++;
            $display("FAIL rm_async: got %b/%h/%h/%0d expected all 0",
                     hs, mem_addr, mem_wdata, i_widx);
        end
        i_req = 0;
        tick();
        tick();
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (hs !== 8'h00 || i_widx !== 2'd0) begin
                errors++;
                $display("FAIL rm_post%0d: got %b/%0d expected 0/0", c, hs, i_widx);
            end
            tick();
        end
        i_req = 1; i_addr = 32'h6000; mem_ack = 1;
        tick();
        checks++;
        if (hs !== 8'hA0 || mem_addr !== 32'h6000 || i_widx !== 2'd0) begin
            errors++;
            $display("FAIL rm_fresh: got %b/%h/%0d expected %b/%h/0",
                     hs, mem_addr, i_widx, 8'hA0, 32'h6000);
        end
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (hs !== 8'h04) begin
            errors++;
            $display("FAIL rm_done: got %b expected %b", hs, 8'h04);
        end
        tick();
        i_req = 0;
        tick();
    endtask

    task automatic test_spurious();
        mem_ack = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (hs !== 8'h00 || i_widx !== 2'd0 || d_widx !== 2'd0) begin
                errors++;
                $display("FAIL sp%0d: got %b/%0d/%0d expected 0/0/0",
                         c, hs, i_widx, d_widx);
            end
            tick();
        end
        i_req = 1; i_addr = 32'h9000;
        tick();
        checks++;
        if (hs !== 8'hA0 || mem_addr !== 32'h9000 || i_widx !== 2'd0) begin
            errors++;
            $display("FAIL sp_idle_kept: got %b/%h/%0d expected %b/%h/0",
                     hs, mem_addr, i_widx, 8'hA0, 32'h9000);
        end
        tick();
        tick();
        tick();
        tick();
        tick();
        i_req = 0; mem_ack = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_i_refill();
        test_d_writeback();
        test_simultaneous();
        test_fairness();
        test_reset_mid();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
